flush_ctrl: RTL and testbench
=============================

# flush_ctrl

Recovery sequencer between the commit stage and the rest of the out-of-order core. When commit signals a branch or JALR redirect (`br_flush`), this block:
- pulses a pipeline-wide flush to ROB, reservation stations, RAT, LSQ and instruction queue;
- holds the frontend stalled until every in-flight imem/dmem transaction has returned;
- hands the corrected PC to fetch over a valid/ready handshake.

It also keeps flush statistics for performance counters.

## Interface
- `CNT_W`, default 3: width of each outstanding-transaction counter (up to 2^CNT_W−1 in flight).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low (0 = reset).
- `br_flush` input 1: commit requests redirect this cycle.
- `br_addr` input 32: corrected target PC, valid with `br_flush`.
- `br_order` input 64: order number of the redirecting instruction.
- `imem_req_issued` input 1: fetch issued an imem read this cycle.
- `imem_resp` input 1: imem response returned this cycle.
- `dmem_req_issued` input 1: LSQ issued a dmem request this cycle.
- `dmem_resp` input 1: dmem response returned this cycle.
- `redirect_ready` input 1: fetch accepts the redirect.
- `flush_pipe` output 1: one-cycle flush pulse to ROB/RS/RAT/LSQ/IQ.
- `stall_frontend` output 1: blocks fetch and issue.
- `discard_imem_resp` output 1: current imem response belongs to the squashed path and must be dropped.
- `redirect_valid` output 1: `redirect_pc` is valid.
- `redirect_pc` output 32: latched `br_addr`.
- `busy` output 1: state is not IDLE.
- `flush_count` output 32: number of accepted flushes.
- `last_flush_order` output 64: `br_order` of the most recent accepted flush.

## Operation
- FSM states: IDLE, FLUSH, DRAIN, REDIRECT. Outputs are Moore-decoded from the state, except `discard_imem_resp`.
- IDLE:
  - `br_flush`=1 → latch `br_addr` into `redirect_pc` and `br_order` into `last_flush_order`; `flush_count` += 1 (wraps modulo 2^32); go to FLUSH.
  - Otherwise stay in IDLE.
- FLUSH, exactly one cycle:
  - `flush_pipe`=1, `stall_frontend`=1; go to DRAIN.
- DRAIN:
  - `stall_frontend`=1.
  - Go to REDIRECT when the registered `imem_cnt`==0 and `dmem_cnt`==0 at the start of the cycle; otherwise stay in DRAIN.
- REDIRECT:
  - `stall_frontend`=1, `redirect_valid`=1.
  - `redirect_pc` is held stable until the handshake.
  - `redirect_valid` && `redirect_ready` → go to IDLE.
- `busy` = (state != IDLE).
- `discard_imem_resp` = `imem_resp` && state ∈ {FLUSH, DRAIN, REDIRECT}. This output is combinational.
- Outstanding counters `imem_cnt` and `dmem_cnt` are CNT_W bits each and update in every state:
  - issue only → +1;
  - resp only → −1;
  - issue and resp in the same cycle → unchanged.
- Counter boundary rules:
  - A resp arriving with count 0 is ignored; the counter stays 0.
  - An issue arriving at the maximum value saturates the counter. This is a protocol violation and is not flagged.
- `br_flush` in any state other than IDLE is ignored: no latch, no count.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE;
  - `flush_pipe`, `stall_frontend`, `redirect_valid`, `busy` = 0;
  - `redirect_pc`=0, `flush_count`=0, `last_flush_order`=0;
  - both counters = 0.
- A reset asserted mid-sequence aborts it immediately; no redirect is issued.
- Fastest sequence (both counters already 0, `redirect_ready` tied 1):
  - cycle 0: `br_flush` sampled;
  - cycle 1: `flush_pipe`=1;
  - cycle 2: DRAIN;
  - cycle 3: `redirect_valid`=1, handshake completes;
  - cycle 4: IDLE, `stall_frontend`=0.
- `flush_pipe` is high for exactly one cycle per accepted flush.
- `stall_frontend` is high from cycle 1 through the handshake cycle, inclusive.
- DRAIN exits on the edge after the counter registers read 0. For example, a resp in cycle N that brings a count to 0 gives REDIRECT at N+2.
- A `redirect_ready` that rises while `redirect_valid` is low has no effect.
- A new `br_flush` in the same cycle as the REDIRECT handshake is ignored. A `br_flush` on the first IDLE cycle after the handshake is accepted.

## Test plan
- **Basic flush:**
  - Stimulus: reset; `br_flush`=1 with `br_addr`=0x0000_1040 and `br_order`=17; `redirect_ready`=1.
  - Required: `flush_pipe` high only at cycle 1; `redirect_valid` at cycle 3 with `redirect_pc`=0x0000_1040; IDLE at cycle 4; `flush_count`=1; `last_flush_order`=17.
- **Drain wait:**
  - Stimulus: 2 imem and 1 dmem requests issued before the flush; responses returned at +4, +6 (imem) and +9 (dmem) cycles after the flush.
  - Required: stays in DRAIN through the cycle after the last resp; `discard_imem_resp`=1 on both imem responses.
- **Backpressure:**
  - Stimulus: `redirect_ready` held 0 for 5 cycles in REDIRECT.
  - Required: `redirect_valid` and `redirect_pc` stay stable; `stall_frontend` stays 1; exit only on the ready cycle.
- **Ignored flush:**
  - Stimulus: second `br_flush` with `br_addr`=0x2000 during DRAIN.
  - Required: `redirect_pc` unchanged; `flush_count` increments once.
- **Counter edges:**
  - Stimulus: simultaneous issue+resp with `imem_cnt`=1; a resp with count 0.
  - Required: count stays 1 in the first case; count stays 0 in the second.
- **Async reset mid-DRAIN:**
  - Stimulus: `rst`=0 between clock edges while in DRAIN.
  - Required: all outputs and counters go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/flush_ctrl.sv
// Branch/JALR recovery sequencer: flushes the core, drains in-flight imem/dmem
// traffic, then hands the corrected PC to fetch over a valid/ready handshake.
module flush_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_flush,
    input  logic [31:0] br_addr,
    input  logic [63:0] br_order,
    input  logic        imem_req_issued,
    input  logic        imem_resp,
    input  logic        dmem_req_issued,
    input  logic        dmem_resp,
    input  logic        redirect_ready,
    output logic        flush_pipe,
    output logic        stall_frontend,
    output logic        discard_imem_resp,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [31:0] flush_count,
    output logic [63:0] last_flush_order
);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] imem_cnt;
    logic [CNT_W-1:0] dmem_cnt;
    logic             accept;

    // Overflow saturates and underflow is dropped; both are protocol errors upstream.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic issue,
                                                  input logic resp);
        logic [CNT_W-1:0] r;
        r = cnt;
        if (issue && !resp && cnt != CNT_MAX)
            r = cnt + 1'b1;
        else if (resp && !issue && cnt != '0)
            r = cnt - 1'b1;
        return r;
    endfunction

    assign accept = (state == IDLE) && br_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (br_flush) state_nxt = FLUSH;
            FLUSH:    state_nxt = DRAIN;
            DRAIN:    if (imem_cnt == '0 && dmem_cnt == '0) state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        flush_pipe        = (state == FLUSH);
        stall_frontend    = (state != IDLE);
        redirect_valid    = (state == REDIRECT);
        busy              = (state != IDLE);
        discard_imem_resp = imem_resp && (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_cnt <= '0;
            dmem_cnt <= '0;
        end else begin
            imem_cnt <= cnt_next(imem_cnt, imem_req_issued, imem_resp);
            dmem_cnt <= cnt_next(dmem_cnt, dmem_req_issued, dmem_resp);
        end
    end

    // Redirect target and statistics only move when a flush is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc      <= '0;
            flush_count      <= '0;
            last_flush_order <= '0;
        end else if (accept) begin
            redirect_pc      <= br_addr;
            flush_count      <= flush_count + 32'd1;
            last_flush_order <= br_order;
        end
    end

endmodule

// File: tb/tb_flush_ctrl.sv
// Self-checking bench for flush_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_flush_ctrl;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_flush, imem_req_issued, imem_resp, dmem_req_issued, dmem_resp, redirect_ready;
    logic [31:0] br_addr;
    logic [63:0] br_order;
    logic        flush_pipe, stall_frontend, discard_imem_resp, redirect_valid, busy;
    logic [31:0] redirect_pc, flush_count;
    logic [63:0] last_flush_order;

    always #5 clk = ~clk;

    flush_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .br_flush(br_flush), .br_addr(br_addr), .br_order(br_order),
        .imem_req_issued(imem_req_issued), .imem_resp(imem_resp),
        .dmem_req_issued(dmem_req_issued), .dmem_resp(dmem_resp),
        .redirect_ready(redirect_ready),
        .flush_pipe(flush_pipe), .stall_frontend(stall_frontend),
        .discard_imem_resp(discard_imem_resp), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy), .flush_count(flush_count),
        .last_flush_order(last_flush_order)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=flush 2=drain 3=redirect; counts as plain clamped integers.
    int          m_ph, m_icnt, m_dcnt;
    logic [31:0] m_pc, m_count;
    logic [63:0] m_order;

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > CMAX) return CMAX;
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = 0; m_icnt = 0; m_dcnt = 0;
            m_pc = '0; m_count = '0; m_order = '0;
        end else begin
            int nph;
            nph = m_ph;
            if (m_ph == 0 && br_flush) begin
                nph = 1; m_pc = br_addr; m_order = br_order; m_count = m_count + 32'd1;
            end else if (m_ph == 1) nph = 2;
            else if (m_ph == 2 && m_icnt == 0 && m_dcnt == 0) nph = 3;
            else if (m_ph == 3 && redirect_ready) nph = 0;
            m_ph   = nph;
            m_icnt = clamp(m_icnt + int'(imem_req_issued) - int'(imem_resp));
            m_dcnt = clamp(m_dcnt + int'(dmem_req_issued) - int'(dmem_resp));
        end
    end

    always @(negedge clk) begin
        if (rst && cmp_en) begin
            chk("m_flush_pipe", flush_pipe, m_ph == 1);
            chk("m_stall", stall_frontend, m_ph != 0);
            chk("m_redirect_valid", redirect_valid, m_ph == 3);
            chk("m_busy", busy, m_ph != 0);
            chk("m_discard", discard_imem_resp, imem_resp && m_ph != 0);
            chk("m_redirect_pc", redirect_pc, m_pc);
            chk("m_flush_count", flush_count, m_count);
            chk("m_last_order", last_flush_order, m_order);
        end
    end

    task automatic nc;
        @(posedge clk);
        #2;
    endtask

    task automatic clr_in;
        br_flush = 0; imem_req_issued = 0; imem_resp = 0;
        dmem_req_issued = 0; dmem_resp = 0;
    endtask

    initial begin
        clr_in();
        br_addr = '0; br_order = '0; redirect_ready = 0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_frontend, 0);
        chk("rst_flush_pipe", flush_pipe, 0);
        chk("rst_valid", redirect_valid, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_count", flush_count, 0);
        chk("rst_order", last_flush_order, 0);
        repeat (2) nc();
        rst = 1'b1;
        cmp_en = 1'b1;

        // Basic flush, fastest path.
        nc(); br_flush = 1; br_addr = 32'h0000_1040; br_order = 64'd17; redirect_ready = 1;
        nc(); br_flush = 0;
        chk("basic_c1_flush", flush_pipe, 1); chk("basic_c1_stall", stall_frontend, 1);
        nc();
        chk("basic_c2_flush", flush_pipe, 0); chk("basic_c2_busy", busy, 1);
        chk("basic_c2_valid", redirect_valid, 0);
        nc();
        chk("basic_c3_valid", redirect_valid, 1); chk("basic_c3_pc", redirect_pc, 32'h1040);
        nc();
        chk("basic_c4_busy", busy, 0); chk("basic_c4_stall", stall_frontend, 0);
        chk("basic_count", flush_count, 1); chk("basic_order", last_flush_order, 17);

        // Drain wait: 2 imem + 1 dmem outstanding.
        nc(); imem_req_issued = 1; dmem_req_issued = 1;
        nc(); dmem_req_issued = 0;
        nc(); imem_req_issued = 0; br_flush = 1; br_addr = 32'h3000; br_order = 64'd99;
        for (int c = 1; c <= 12; c++) begin
            nc();
            br_flush = 0;
            imem_resp = (c == 4 || c == 6);
            dmem_resp = (c == 9);
            #1;
            if (c == 4 || c == 6) chk("drain_discard", discard_imem_resp, 1);
            if (c >= 2 && c <= 10) chk("drain_hold", redirect_valid, 0);
            if (c == 11) chk("drain_exit", redirect_valid, 1);
            if (c == 12) chk("drain_idle", busy, 0);
        end
        clr_in();

        // Backpressure with an ignored flush during DRAIN.
        nc(); imem_req_issued = 1; redirect_ready = 0;
        nc(); imem_req_issued = 0; br_flush = 1; br_addr = 32'h5550; br_order = 64'd5;
        nc(); br_flush = 0;
        nc(); br_flush = 1; br_addr = 32'h2000; br_order = 64'd777;
        nc(); br_flush = 0; imem_resp = 1;
        chk("ign_pc", redirect_pc, 32'h5550); chk("ign_count", flush_count, 3);
        chk("ign_order", last_flush_order, 5);
        nc(); imem_resp = 0;
        nc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", redirect_valid, 1); chk("bp_pc", redirect_pc, 32'h5550);
            chk("bp_stall", stall_frontend, 1);
            nc();
        end
        redirect_ready = 1;
        chk("bp_last_valid", redirect_valid, 1);
        nc();
        chk("bp_exit", busy, 0); chk("bp_count", flush_count, 3);

        // Counter edges: resp at zero, then issue+resp at one.
        nc(); imem_resp = 1;
        nc(); imem_resp = 0; imem_req_issued = 1;
        nc(); imem_resp = 1;
        nc(); imem_req_issued = 0; imem_resp = 0; br_flush = 1; br_addr = 32'h60;
        for (int c = 1; c <= 9; c++) begin
            nc();
            br_flush = 0;
            imem_resp = (c == 6);
            #1;
            if (c >= 2 && c <= 7) chk("cnt_hold", redirect_valid, 0);
            if (c == 8) chk("cnt_exit", redirect_valid, 1);
            if (c == 9) chk("cnt_idle", busy, 0);
        end
        clr_in();

        // Asynchronous reset in DRAIN.
        nc(); imem_req_issued = 1;
        nc(); imem_req_issued = 0; br_flush = 1; br_addr = 32'h7000;
        nc(); br_flush = 0;
        nc();
        #1 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_stall", stall_frontend, 0);
        chk("arst_valid", redirect_valid, 0); chk("arst_flush", flush_pipe, 0);
        chk("arst_pc", redirect_pc, 0); chk("arst_count", flush_count, 0);
        chk("arst_order", last_flush_order, 0);
        nc(); rst = 1'b1;
        nc(); br_flush = 1; br_addr = 32'h8000;
        for (int c = 1; c <= 4; c++) begin
            nc();
            br_flush = 0;
            if (c == 3) chk("arst_cnt_zero", redirect_valid, 1);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            nc();
            rst             = ($urandom_range(0, 599) != 0);
            br_flush        = ($urandom_range(0, 5) == 0);
            br_addr         = $urandom;
            br_order        = {$urandom, $urandom};
            imem_req_issued = ($urandom_range(0, 2) < ((n % 400 < 200) ? 2 : 1));
            imem_resp       = ($urandom_range(0, 2) == 0);
            dmem_req_issued = ($urandom_range(0, 2) == 0);
            dmem_resp       = ($urandom_range(0, 2) == 0);
            redirect_ready  = $urandom_range(0, 1);
        end
        nc(); rst = 1'b1; clr_in();
        nc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
